bp_fe_bht_wbuf: RTL and testbench
=================================

// Module: bp_fe_bht_wbuf
//
// PURPOSE
//  Write buffer between the FE update path (redirect/attaboy) and the BHT write port.
//  Holds pending counter updates and presents one at a time to the BHT.
//  Retries an update while the BHT refuses it (init sweep, read/write index conflict).
//  Merges back-to-back updates to the same {idx,ghist} row.
//  Updates are hints: when the buffer is full a new update is dropped, never stalled.
//
// PARAMETERS
//  bp_params_p      e_bp_default_cfg  processor config; supplies bht_idx_width_p, ghist_width_p, bht_row_width_p
//  els_p            4                 buffer depth in entries; must be >= 2
//  cnt_width_lp     `BSG_WIDTH(els_p)  width of count_o (localparam)
//
// PORTS
//  clk_i        in   1                 clock
//  reset_i      in   1                 synchronous, active-high reset
//  init_done_i  in   1                 BHT has finished its clear sweep
//  v_i          in   1                 update valid; always accepted (enqueued, merged or dropped)
//  idx_i        in   bht_idx_width_p   BHT row index of update
//  ghist_i      in   ghist_width_p     global history used with idx_i
//  val_i        in   bht_row_width_p   row value read at prediction time
//  correct_i    in   1                 prediction was correct
//  w_v_o        out  1                 head entry valid towards BHT
//  w_idx_o      out  bht_idx_width_p   head idx
//  w_ghist_o    out  ghist_width_p     head ghist
//  w_val_o      out  bht_row_width_p   head row value
//  w_correct_o  out  1                 head correct flag
//  w_yumi_i     in   1                 BHT consumed head this cycle; legal only when w_v_o=1
//  drop_o       out  1                 v_i this cycle was discarded (buffer full, no merge)
//  count_o      out  cnt_width_lp      number of occupied entries, 0..els_p
//
// BEHAVIOUR
//  - Circular FIFO: head/tail pointers with wrap at els_p, plus an occupancy counter.
//  - Reset: empty; count_o=0, w_v_o=0, drop_o=0; w_* data outputs 0.
//    Reset mid-operation discards all entries in the next cycle.
//  - Output: w_v_o = (count_o!=0) & init_done_i.
//    w_* data come from the head register (registered; no input bypass).
//    Head data hold stable while w_v_o & ~w_yumi_i.
//  - Latency: v_i enqueued at cycle t gives w_v_o=1 at t+1 at the earliest.
//  - Dequeue: when w_yumi_i=1, pop head and advance the head pointer with wrap.
//  - Merge: v_i merges when all of the following hold:
//      * the buffer is non-empty;
//      * {idx_i,ghist_i} equals the tail entry's {idx,ghist};
//      * the tail entry is not being dequeued this cycle (tail!=head or w_yumi_i=0).
//    On merge, the tail's val and correct are overwritten (newest wins).
//    count_o is unchanged by the merge.
//  - Enqueue: when v_i=1 and no merge, the entry is written at tail and the tail pointer advances with wrap.
//    This happens if count<els_p, or if count==els_p with w_yumi_i=1 (pop frees a slot the same cycle).
//  - Drop: when v_i=1, no merge, count==els_p and w_yumi_i=0, set drop_o=1 (combinational, same cycle).
//    State is unchanged.
//  - Simultaneous enqueue and dequeue: count unchanged.
//    With count==1 and w_yumi_i=1, a matching v_i enqueues as a new entry; it does not merge.
//  - init_done_i=0: updates still accepted, merged or dropped; nothing drains.
//  - Assertions: w_yumi_i=1 with w_v_o=0 is illegal; count_o never exceeds els_p.
//
// TESTING
//  1. Reset, then v_i idx=5 ghist=1 at t with init_done_i=1, w_yumi_i=1 at t+1
//     -> w_v_o=1 and w_idx_o=5 at t+1; count_o=0 at t+2.
//  2. init_done_i=0, 5 distinct updates -> count_o=4; drop_o=1 only on the 5th.
//     Then raise init_done_i and ack every cycle -> the 4 entries drain in order.
//  3. Two consecutive v_i to the same {idx,ghist} with val 0x01 then 0x03, head held (w_yumi_i=0)
//     -> count_o=1; w_val_o=0x03.
//  4. count_o=1, same-key v_i with w_yumi_i=1 in the same cycle
//     -> no merge; count_o stays 1; new entry is presented next cycle.
//  5. Full buffer, v_i and w_yumi_i in the same cycle -> drop_o=0, count_o stays 4.
//     Pointers wrap and FIFO order is preserved over 3 full wraps.
//  6. Assert reset_i while count_o=3 -> next cycle count_o=0, w_v_o=0.

Source files
------------

// File: rtl/bp_fe_bht_wbuf.sv
// Write buffer between the FE update path and the BHT write port.
// Queues counter updates, merges same-row bursts, drops when full.
module bp_fe_bht_wbuf #(
  parameter int bht_idx_width_p = 9,
  parameter int ghist_width_p   = 2,
  parameter int bht_row_width_p = 8,
  parameter int els_p           = 4,
  localparam int cnt_width_lp   = $clog2(els_p+1)
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       init_done_i,
  input  logic                       v_i,
  input  logic [bht_idx_width_p-1:0] idx_i,
  input  logic [ghist_width_p-1:0]   ghist_i,
  input  logic [bht_row_width_p-1:0] val_i,
  input  logic                       correct_i,
  output logic                       w_v_o,
  output logic [bht_idx_width_p-1:0] w_idx_o,
  output logic [ghist_width_p-1:0]   w_ghist_o,
  output logic [bht_row_width_p-1:0] w_val_o,
  output logic                       w_correct_o,
  input  logic                       w_yumi_i,
  output logic                       drop_o,
  output logic [cnt_width_lp-1:0]    count_o
);

  localparam int ptr_w_lp = $clog2(els_p);
  localparam logic [ptr_w_lp-1:0] last_lp = ptr_w_lp'(els_p-1);

  typedef struct packed {
    logic [bht_idx_width_p-1:0] idx;
    logic [ghist_width_p-1:0]   ghist;
    logic [bht_row_width_p-1:0] val;
    logic                       correct;
  } entry_t;

  entry_t                mem_q [els_p];
  logic [ptr_w_lp-1:0]   head_q, head_d;
  logic [ptr_w_lp-1:0]   tail_q, tail_d;
  logic [ptr_w_lp-1:0]   last_ptr;
  logic [cnt_width_lp-1:0] count_q, count_d;

  entry_t head_ent, tail_ent, new_ent;
  logic   empty, full, deq, key_hit;
  logic   merge, drop, enq;

  function automatic logic [ptr_w_lp-1:0] ptr_inc(
    input logic [ptr_w_lp-1:0] p
  );
    return (p == last_lp) ? '0 : p + ptr_w_lp'(1);
  endfunction

  // Most recently written slot, one behind the tail pointer
  assign last_ptr = (tail_q == '0) ? last_lp
                                   : tail_q - ptr_w_lp'(1);

  assign head_ent = mem_q[head_q];
  assign tail_ent = mem_q[last_ptr];

  assign new_ent.idx     = idx_i;
  assign new_ent.ghist   = ghist_i;
  assign new_ent.val     = val_i;
  assign new_ent.correct = correct_i;

  assign empty   = (count_q == '0);
  assign full    = (count_q == cnt_width_lp'(els_p));
  assign w_v_o   = ~empty & init_done_i;
  assign deq     = w_yumi_i & w_v_o;
  assign key_hit = (tail_ent.idx == idx_i)
                 & (tail_ent.ghist == ghist_i);

  // A tail that is leaving this cycle cannot absorb the update
  assign merge = v_i & ~empty & key_hit
               & ~(deq & (last_ptr == head_q));
  assign drop  = v_i & ~merge & full & ~deq;
  assign enq   = v_i & ~merge & ~drop;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (deq) head_d = ptr_inc(head_q);
    if (enq) tail_d = ptr_inc(tail_q);
    case ({enq, deq})
      2'b10:   count_d = count_q + cnt_width_lp'(1);
      2'b01:   count_d = count_q - cnt_width_lp'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < els_p; i++)
        mem_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (merge) begin
        mem_q[last_ptr].val     <= val_i;
        mem_q[last_ptr].correct <= correct_i;
      end
      if (enq)
        mem_q[tail_q] <= new_ent;
    end
  end

  assign w_idx_o     = head_ent.idx;
  assign w_ghist_o   = head_ent.ghist;
  assign w_val_o     = head_ent.val;
  assign w_correct_o = head_ent.correct;
  assign drop_o      = drop;
  assign count_o     = count_q;

  a_yumi_legal: assert property (
    @(posedge clk_i) disable iff (reset_i)
      !(w_yumi_i && !w_v_o));

  a_count_max: assert property (
    @(posedge clk_i) disable iff (reset_i)
      count_q <= cnt_width_lp'(els_p));

endmodule

// File: tb/tb_bp_fe_bht_wbuf.sv
// Directed bench for bp_fe_bht_wbuf.
// Inputs change 1ns after posedge; outputs are checked there too.
module tb_bp_fe_bht_wbuf;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       init_done_i;
  logic       v_i;
  logic [8:0] idx_i;
  logic [1:0] ghist_i;
  logic [7:0] val_i;
  logic       correct_i;
  logic       w_v_o;
  logic [8:0] w_idx_o;
  logic [1:0] w_ghist_o;
  logic [7:0] w_val_o;
  logic       w_correct_o;
  logic       w_yumi_i;
  logic       drop_o;
  logic [2:0] count_o;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  bp_fe_bht_wbuf dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .init_done_i (init_done_i),
    .v_i         (v_i),
    .idx_i       (idx_i),
    .ghist_i     (ghist_i),
    .val_i       (val_i),
    .correct_i   (correct_i),
    .w_v_o       (w_v_o),
    .w_idx_o     (w_idx_o),
    .w_ghist_o   (w_ghist_o),
    .w_val_o     (w_val_o),
    .w_correct_o (w_correct_o),
    .w_yumi_i    (w_yumi_i),
    .drop_o      (drop_o),
    .count_o     (count_o)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic upd(input logic v, input logic [8:0] idx,
                     input logic [1:0] gh, input logic [7:0] val,
                     input logic cor);
    v_i       = v;
    idx_i     = idx;
    ghist_i   = gh;
    val_i     = val;
    correct_i = cor;
    #1;
  endtask

  initial begin
    reset_i     = 1'b1;
    init_done_i = 1'b1;
    w_yumi_i    = 1'b0;
    upd(1'b0, '0, '0, '0, 1'b0);
    cyc();
    cyc();
    chk("rst_count", count_o, 0);
    chk("rst_wv", w_v_o, 0);
    chk("rst_drop", drop_o, 0);
    chk("rst_widx", w_idx_o, 0);
    chk("rst_wval", w_val_o, 0);
    reset_i = 1'b0;
    cyc();

    // 1: single update, latency and pop
    upd(1'b1, 9'd5, 2'd1, 8'h02, 1'b1);
    chk("t1_drop", drop_o, 0);
    cyc();
    upd(1'b0, '0, '0, '0, 1'b0);
    chk("t1_wv", w_v_o, 1);
    chk("t1_widx", w_idx_o, 5);
    chk("t1_wgh", w_ghist_o, 1);
    chk("t1_wval", w_val_o, 8'h02);
    chk("t1_wcor", w_correct_o, 1);
    w_yumi_i = 1'b1;
    cyc();
    w_yumi_i = 1'b0;
    #1;
    chk("t1_count", count_o, 0);
    chk("t1_wv0", w_v_o, 0);

    // 2: fill without drain, 5th dropped, then drain in order
    init_done_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      upd(1'b1, 9'(10 + i), 2'(i), 8'(8'h10 + i), 1'b0);
      chk("t2_drop", drop_o, (i == 4) ? 1 : 0);
      cyc();
    end
    upd(1'b0, '0, '0, '0, 1'b0);
    chk("t2_count", count_o, 4);
    chk("t2_wv_blocked", w_v_o, 0);
    init_done_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_wv", w_v_o, 1);
      chk("t2_widx", w_idx_o, 10 + i);
      chk("t2_wval", w_val_o, 8'h10 + i);
      w_yumi_i = 1'b1;
      cyc();
    end
    w_yumi_i = 1'b0;
    #1;
    chk("t2_empty", count_o, 0);

    // 3: merge into held head, newest wins
    upd(1'b1, 9'd7, 2'd2, 8'h01, 1'b0);
    cyc();
    upd(1'b1, 9'd7, 2'd2, 8'h03, 1'b1);
    chk("t3_drop", drop_o, 0);
    cyc();
    upd(1'b0, '0, '0, '0, 1'b0);
    chk("t3_count", count_o, 1);
    chk("t3_wval", w_val_o, 8'h03);
    chk("t3_wcor", w_correct_o, 1);
    chk("t3_widx", w_idx_o, 7);

    // 4: same key while the sole entry pops -> new entry
    w_yumi_i = 1'b1;
    upd(1'b1, 9'd7, 2'd2, 8'h05, 1'b0);
    chk("t4_head_old", w_val_o, 8'h03);
    cyc();
    w_yumi_i = 1'b0;
    upd(1'b0, '0, '0, '0, 1'b0);
    chk("t4_count", count_o, 1);
    chk("t4_wv", w_v_o, 1);
    chk("t4_wval", w_val_o, 8'h05);
    w_yumi_i = 1'b1;
    cyc();
    w_yumi_i = 1'b0;
    #1;
    chk("t4_empty", count_o, 0);

    // 5: full with push+pop every cycle over 3 wraps
    for (int i = 0; i < 4; i++) begin
      upd(1'b1, 9'(20 + i), 2'd0, 8'(i), 1'b0);
      cyc();
    end
    chk("t5_full", count_o, 4);
    for (int j = 0; j < 12; j++) begin
      upd(1'b1, 9'(24 + j), 2'd0, 8'(4 + j), 1'b0);
      w_yumi_i = 1'b1;
      #1;
      chk("t5_drop", drop_o, 0);
      chk("t5_widx", w_idx_o, 20 + j);
      chk("t5_wval", w_val_o, j);
      cyc();
      chk("t5_count", count_o, 4);
    end
    upd(1'b0, '0, '0, '0, 1'b0);
    w_yumi_i = 1'b0;
    #1;
    chk("t5_head", w_idx_o, 32);

    // 6: reset with three entries held
    w_yumi_i = 1'b1;
    cyc();
    w_yumi_i = 1'b0;
    #1;
    chk("t6_count3", count_o, 3);
    chk("t6_head", w_idx_o, 33);
    reset_i = 1'b1;
    cyc();
    chk("t6_count", count_o, 0);
    chk("t6_wv", w_v_o, 0);
    chk("t6_widx", w_idx_o, 0);
    reset_i = 1'b0;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
